serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. One 1-bit full-adder cell is reused LSB-first over WIDTH cycles.
Computes a+b+cin (sub=0) or a-b-cin (sub=1) with a start/busy/done handshake.
Serves as the area-minimal arithmetic unit for the combinational-to-sequential track of the library.
It is the successor to the single-bit full adder: generalised in width, with subtract mode, overflow detection and multi-cycle control.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; sampled on the accepting edge
b  input  WIDTH  operand B; sampled on the accepting edge
cin  input  1  carry-in (sub=0) or borrow-in (sub=1); sampled on the accepting edge
sub  input  1  0=add, 1=subtract; sampled on the accepting edge
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
sum  output  WIDTH  registered result
cout  output  1  carry-out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state=IDLE; busy, done, sum, cout, ovf all 0; internal shift registers, carry and counter all 0.
- Reset mid-operation: the operation is aborted with no result update. The next start is accepted on the first edge after rst deasserts.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary.
- IDLE, start=1 at edge k:
  - Load A_sh=a.
  - Load B_sh = sub ? ~b : b.
  - Load carry = sub ? ~cin : cin.
  - cnt=0; state goes to RUN; busy=1 from edge k.
- RUN, each edge:
  - Full-adder cell on (A_sh[0], B_sh[0], carry) yields s_bit and c_bit.
  - s_bit shifts into the result register MSB side (right shift).
  - A_sh and B_sh shift right; carry<=c_bit.
  - At cnt==WIDTH-1, capture c_msb_in = carry before the update. This is the carry into the MSB.
  - cnt increments.
- RUN, edge k+WIDTH (cnt==WIDTH-1):
  - Result is complete: sum<=assembled result, cout<=c_bit, ovf<=c_msb_in XOR c_bit.
  - busy<=0, done<=1, state goes to DONE.
- DONE: done is high for exactly one cycle. At the next edge:
  - start=1: accept a new operation as in IDLE (back-to-back, busy=1, done=0).
  - start=0: go to IDLE with done=0.
- Latency: done visible WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+1 cycles.
- sum, cout and ovf update only at completion. They hold stable otherwise, including during the next operation.
- start while busy=1 is ignored; no queuing. Operand changes during RUN have no effect.
- Wrap-around: sum is modulo 2^WIDTH. cout carries the unsigned carry out (or the inverted borrow in sub mode).
- cnt never exceeds WIDTH-1.

Decomposition:
- Shared package/include serial_addsub_pkg:
  - state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module fa_cell: structural 1-bit full adder (a, b, ci -> s, co) built from xor/and/or primitives. Instantiated once.
- Top contains FSM, counter, shift registers and output registers.

Test Plan (WIDTH=8):
- rst=1 for 2 cycles -> busy=0, done=0, sum=0x00, cout=0, ovf=0.
- Add 0x5A+0x3C, cin=0 -> done at edge k+8; sum=0x96, cout=0, ovf=1.
- Add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x00+0x00, cin=1 -> sum=0x01, cout=0.
- Sub 0x10-0x20, cin=0 -> sum=0xF0, cout=0, ovf=0. Sub 0x80-0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
- Start pulse at cycle 3 of a RUN with different operands -> ignored; first result unchanged. Start held during DONE -> new op accepted, busy=1 the next cycle, done high exactly one cycle.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, sum keeps reset value 0. A following add 0x01+0x01 -> sum=0x02.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module   : serial_addsub_pkg
// Brief    : Shared state encoding and default width for the serial add/sub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
// ============================================================================
// Module   : fa_cell
// Brief    : Structural 1-bit full adder built from gate primitives.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    wire w_p;
    wire w_g;
    wire w_pc;
    wire w_s;
    wire w_co;

    xor u_xor_p  (w_p,  a,   b);
    xor u_xor_s  (w_s,  w_p, ci);
    and u_and_g  (w_g,  a,   b);
    and u_and_pc (w_pc, w_p, ci);
    or  u_or_co  (w_co, w_g, w_pc);

    assign s  = w_s;
    assign co = w_co;

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module   : serial_addsub
// Brief    : Bit-serial adder/subtractor, LSB first, one full-adder cell reused
//            over WIDTH cycles with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_s_bit;
    logic               w_c_bit;
    logic               w_last;

    fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (w_s_bit),
        .co (w_c_bit)
    );

    assign w_last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    // Subtraction as a + ~b + ~borrow_in
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = {w_s_bit, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = w_c_bit;
                if (w_last) begin
                    // carry_q is still the carry into the MSB on this edge
                    sum_d   = {w_s_bit, res_q[WIDTH-1:1]};
                    cout_d  = w_c_bit;
                    ovf_d   = carry_q ^ w_c_bit;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module   : tb_serial_addsub
// Brief    : Scoreboard bench for serial_addsub (WIDTH=8), directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    string  cur_test = "reset";

    logic [W-1:0] last_s = '0;
    logic         last_c = 1'b0;
    logic         last_o = 1'b0;
    logic         prev_done = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h (cycle %0d)", cur_test, name, act, exp, cyc);
        end
    endtask

    // Monitor: samples shortly after each active edge, pops on done
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum",  32'(sum),  32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            check("rst_ovf",  32'(ovf),  32'd0);
            last_s    = '0;
            last_c    = 1'b0;
            last_o    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done)
                check("done_one_cycle", 32'(done), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_done: got done=1 expected no result pending", cur_test);
                end else begin
                    e = sb.pop_front();
                    check("sum",     32'(sum),  32'(e.s));
                    check("cout",    32'(cout), 32'(e.c));
                    check("ovf",     32'(ovf),  32'(e.o));
                    check("latency", 32'(cyc - e.acc), 32'(W));
                    last_s = e.s;
                    last_c = e.c;
                    last_o = e.o;
                end
            end else begin
                check("hold", 32'({sum, cout, ovf}), 32'({last_s, last_c, last_o}));
            end
            prev_done = done;
        end
    end

    // Called just after a negedge; returns just after the following negedge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input bit push);
        exp_t e;
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        start = 1'b1;
        if (push) begin
            e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("accept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: got no done expected done within 40 cycles", cur_test);
        end
    endtask

    task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        issue(ia, ib, icin, isub, es, ec, eo, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        cur_test = "add_5a_3c";  run(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        cur_test = "add_ff_01";  run(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cur_test = "add_cin";    run(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        cur_test = "sub_10_20";  run(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        cur_test = "sub_80_01";  run(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start pulse with different operands mid-RUN must be ignored
        cur_test = "start_in_run";
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check("still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Back-to-back: new op accepted from DONE
        cur_test = "back_to_back";
        issue(8'h70, 8'h70, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b1);
        wait_done();
        issue(8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset mid-operation aborts without a result
        cur_test = "reset_mid_run";
        issue(8'h55, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_test = "add_after_reset";
        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
